// File: rtl/hit_judge.sv
// Drum hit judge: opens a timing window when a note arrives and scores the
// first drum press in it as correct, wrong, or a miss, tracking a hit combo.
module hit_judge #(
    parameter int unsigned WINDOW = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       note_arrive,
    input  logic       note_type,
    input  logic       drum_don,
    input  logic       drum_ka,
    output logic       increase_score,
    output logic       decrease_score,
    output logic [7:0] combo,
    output logic       pending
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;
    localparam logic [7:0] WIN     = 8'(WINDOW);

    logic [0:0] state;
    logic [7:0] count;
    logic       stored_type;
    logic       don_q;
    logic       ka_q;
    logic       don_arm;
    logic       ka_arm;

    logic       press_don;
    logic       press_ka;
    logic       match;
    logic       judge_inc;
    logic       judge_dec;

    // A drum is armed only once it has been seen released since reset,
    // so a drum held through reset never reads as a fresh press.
    assign press_don = drum_don & ~don_q & don_arm;
    assign press_ka  = drum_ka & ~ka_q & ka_arm;

    // Judge the pending note: a press decides it, otherwise a new arrival
    // or the last window edge turns it into a miss.
    always_comb begin
        judge_inc = 1'b0;
        judge_dec = 1'b0;
        match = stored_type ? (press_ka & ~press_don)
                            : (press_don & ~press_ka);
        if (state == PENDING) begin
            if (press_don | press_ka) begin
                judge_inc = match;
                judge_dec = ~match;
            end else if (note_arrive || count == 8'd1) begin
                judge_dec = 1'b1;
            end
        end
    end

    // Drum edge detection registers and arming flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            don_q   <= 1'b0;
            ka_q    <= 1'b0;
            don_arm <= 1'b0;
            ka_arm  <= 1'b0;
        end else begin
            don_q   <= drum_don;
            ka_q    <= drum_ka;
            don_arm <= don_arm | ~drum_don;
            ka_arm  <= ka_arm | ~drum_ka;
        end
    end

    // Note state: a new arrival always wins, after the old note is judged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            count       <= 8'd0;
            stored_type <= 1'b0;
        end else if (note_arrive) begin
            state       <= PENDING;
            count       <= WIN;
            stored_type <= note_type;
        end else if (judge_inc | judge_dec) begin
            state <= IDLE;
            count <= 8'd0;
        end else if (state == PENDING) begin
            count <= count - 8'd1;
        end
    end

    // Registered score pulses and saturating combo counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            increase_score <= 1'b0;
            decrease_score <= 1'b0;
            combo          <= 8'd0;
        end else begin
            increase_score <= judge_inc;
            decrease_score <= judge_dec;
            if (judge_inc) begin
                if (combo != 8'hFF) combo <= combo + 8'd1;
            end else if (judge_dec) begin
                combo <= 8'd0;
            end
        end
    end

    assign pending = (state == PENDING);

endmodule

// File: tb/tb_hit_judge.sv
// Directed testbench for hit_judge with WINDOW = 16.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_hit_judge;

    logic       clk = 1'b0;
    logic       resetn;
    logic       note_arrive;
    logic       note_type;
    logic       drum_don;
    logic       drum_ka;
    logic       increase_score;
    logic       decrease_score;
    logic [7:0] combo;
    logic       pending;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;

    hit_judge #(.WINDOW(16)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .note_arrive    (note_arrive),
        .note_type      (note_type),
        .drum_don       (drum_don),
        .drum_ka        (drum_ka),
        .increase_score (increase_score),
        .decrease_score (decrease_score),
        .combo          (combo),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    // Both score pulses in one cycle is never legal.
    always @(negedge clk) if (increase_score && decrease_score) overlap++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arrive(input logic t);
        note_arrive = 1'b1;
        note_type   = t;
        tick();
        note_arrive = 1'b0;
        note_type   = 1'b0;
    endtask

    task automatic quick_hit();
        arrive(1'b0);
        drum_don = 1'b1;
        tick();
        drum_don = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        note_arrive = 1'b0;
        note_type = 1'b0;
        drum_don = 1'b0;
        drum_ka = 1'b0;
        #2;
        checks++;
        if ({increase_score, decrease_score, combo, pending} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outs got=%b exp=0",
                     {increase_score, decrease_score, combo, pending});
        end
        tick();
        resetn = 1'b1;
        tick();
        checks++;
        if (pending !== 1'b0 || combo !== 8'd0) begin
            failures++;
            $display("FAIL reset_release pending=%b combo=%0d exp 0/0",
                     pending, combo);
        end
    endtask

    task automatic test_hit();
        arrive(1'b0);
        checks++;
        if (pending !== 1'b1) begin
            failures++;
            $display("FAIL hit_pending got=%b exp=1", pending);
        end
        repeat (4) tick();
        drum_don = 1'b1;
        tick();
        drum_don = 1'b0;
        checks++;
        if (increase_score !== 1'b1 || decrease_score !== 1'b0 ||
            combo !== 8'd1 || pending !== 1'b0) begin
            failures++;
            $display("FAIL hit_judge inc=%b dec=%b combo=%0d pend=%b exp 1/0/1/0",
                     increase_score, decrease_score, combo, pending);
        end
        tick();
        checks++;
        if (increase_score !== 1'b0) begin
            failures++;
            $display("FAIL hit_pulse_width got=%b exp=0", increase_score);
        end
    endtask

    task automatic test_miss();
        int early = 0;
        arrive(1'b1);
        repeat (15) begin
            tick();
            if (decrease_score || !pending) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL miss_early got=%0d exp=0", early);
        end
        tick();
        checks++;
        if (decrease_score !== 1'b1 || combo !== 8'd0 || pending !== 1'b0) begin
            failures++;
            $display("FAIL miss_edge dec=%b combo=%0d pend=%b exp 1/0/0",
                     decrease_score, combo, pending);
        end
        tick();
        checks++;
        if (decrease_score !== 1'b0) begin
            failures++;
            $display("FAIL miss_pulse_width got=%b exp=0", decrease_score);
        end
    endtask

    task automatic test_late_hit();
        arrive(1'b1);
        repeat (15) tick();
        drum_ka = 1'b1;
        tick();
        drum_ka = 1'b0;
        checks++;
        if (increase_score !== 1'b1 || decrease_score !== 1'b0 ||
            combo !== 8'd1) begin
            failures++;
            $display("FAIL late_hit inc=%b dec=%b combo=%0d exp 1/0/1",
                     increase_score, decrease_score, combo);
        end
    endtask

    task automatic test_wrong();
        arrive(1'b0);
        tick();
        drum_ka = 1'b1;
        tick();
        drum_ka = 1'b0;
        checks++;
        if (decrease_score !== 1'b1 || increase_score !== 1'b0 ||
            combo !== 8'd0 || pending !== 1'b0) begin
            failures++;
            $display("FAIL wrong_drum dec=%b inc=%b combo=%0d pend=%b exp 1/0/0/0",
                     decrease_score, increase_score, combo, pending);
        end
    endtask

    task automatic test_both();
        quick_hit();
        arrive(1'b0);
        drum_don = 1'b1;
        drum_ka = 1'b1;
        tick();
        drum_don = 1'b0;
        drum_ka = 1'b0;
        checks++;
        if (decrease_score !== 1'b1 || increase_score !== 1'b0 ||
            combo !== 8'd0) begin
            failures++;
            $display("FAIL both_drums dec=%b inc=%b combo=%0d exp 1/0/0",
                     decrease_score, increase_score, combo);
        end
    endtask

    task automatic test_idle_press();
        quick_hit();
        tick();
        drum_don = 1'b1;
        tick();
        drum_don = 1'b0;
        drum_ka = 1'b1;
        tick();
        drum_ka = 1'b0;
        checks++;
        if (increase_score !== 1'b0 || decrease_score !== 1'b0 ||
            combo !== 8'd1) begin
            failures++;
            $display("FAIL idle_press inc=%b dec=%b combo=%0d exp 0/0/1",
                     increase_score, decrease_score, combo);
        end
    endtask

    task automatic test_held();
        int spurious = 0;
        drum_don = 1'b1;
        tick();
        arrive(1'b0);
        repeat (3) begin
            tick();
            if (increase_score || decrease_score) spurious++;
        end
        checks++;
        if (spurious != 0 || pending !== 1'b1) begin
            failures++;
            $display("FAIL held_level spurious=%0d pend=%b exp 0/1",
                     spurious, pending);
        end
        drum_don = 1'b0;
        tick();
        drum_don = 1'b1;
        tick();
        drum_don = 1'b0;
        checks++;
        if (increase_score !== 1'b1 || combo !== 8'd2) begin
            failures++;
            $display("FAIL held_repress inc=%b combo=%0d exp 1/2",
                     increase_score, combo);
        end
    endtask

    task automatic test_back_to_back();
        arrive(1'b0);
        repeat (3) tick();
        arrive(1'b1);
        checks++;
        if (decrease_score !== 1'b1 || pending !== 1'b1 || combo !== 8'd0) begin
            failures++;
            $display("FAIL b2b_old_miss dec=%b pend=%b combo=%0d exp 1/1/0",
                     decrease_score, pending, combo);
        end
        tick();
        checks++;
        if (decrease_score !== 1'b0 || pending !== 1'b1) begin
            failures++;
            $display("FAIL b2b_new_pending dec=%b pend=%b exp 0/1",
                     decrease_score, pending);
        end
        drum_ka = 1'b1;
        tick();
        drum_ka = 1'b0;
        checks++;
        if (increase_score !== 1'b1 || combo !== 8'd1 || pending !== 1'b0) begin
            failures++;
            $display("FAIL b2b_new_hit inc=%b combo=%0d pend=%b exp 1/1/0",
                     increase_score, combo, pending);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            quick_hit();
            if (i == 253) begin
                checks++;
                if (combo !== 8'd255) begin
                    failures++;
                    $display("FAIL sat_reach got=%0d exp=255", combo);
                end
            end
        end
        checks++;
        if (combo !== 8'd255) begin
            failures++;
            $display("FAIL sat_hold got=%0d exp=255", combo);
        end
        arrive(1'b1);
        repeat (16) tick();
        checks++;
        if (decrease_score !== 1'b1 || combo !== 8'd0) begin
            failures++;
            $display("FAIL sat_miss dec=%b combo=%0d exp 1/0",
                     decrease_score, combo);
        end
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        quick_hit();
        arrive(1'b0);
        tick();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({increase_score, decrease_score, combo, pending} !== 11'd0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=0",
                     {increase_score, decrease_score, combo, pending});
        end
        #2;
        resetn = 1'b1;
        repeat (20) begin
            tick();
            if (increase_score || decrease_score || pending) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL async_discard got=%0d exp=0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_late_hit();
        test_wrong();
        test_both();
        test_idle_press();
        test_held();
        test_back_to_back();
        test_saturate();
        test_async_reset();
        checks++;
        if (overlap != 0) begin
            failures++;
            $display("FAIL score_overlap got=%0d exp=0", overlap);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 SHALL have parameter WINDOW, default 16: number of clock edges after note arrival during which a drum hit is judged (legal 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port note_arrive  input  1  one-cycle pulse: a note entered the hit zone.
REQ-005 SHALL have port note_type  input  1  type of the arriving note, sampled with note_arrive (0 = don/red, 1 = ka/blue).
REQ-006 SHALL have port drum_don  input  1  debounced don drum level, active-high.
REQ-007 SHALL have port drum_ka  input  1  debounced ka drum level, active-high.
REQ-008 SHALL have port increase_score  output  1  one-cycle pulse: correct hit; drives the score counter.
REQ-009 SHALL have port decrease_score  output  1  one-cycle pulse: wrong hit or miss; drives the score counter.
REQ-010 SHALL have port combo  output  8  unsigned count of consecutive correct hits.
REQ-011 SHALL have port pending  output  1  high while a note awaits judgement.

Function
REQ-012 SHALL register drum_don and drum_ka each cycle; a press is input high at edge k while its registered value (from edge k-1) is low; held levels SHALL NOT re-trigger.
REQ-013 SHALL implement FSM states IDLE and PENDING, with an 8-bit window counter and a 1-bit stored note type.
REQ-014 In IDLE, note_arrive at edge k SHALL store note_type, load counter = WINDOW, and enter PENDING.
REQ-015 In IDLE, drum presses SHALL be ignored: no score pulse, combo unchanged.
REQ-016 In PENDING, a press of only the matching drum SHALL assert increase_score, saturate-increment combo (255 holds), and return to IDLE.
REQ-017 In PENDING, a press of only the non-matching drum SHALL assert decrease_score, clear combo, and return to IDLE.
REQ-018 In PENDING, presses of both drums at the same edge SHALL be treated as a wrong hit (REQ-017).
REQ-019 In PENDING with no press: if counter = 1, SHALL assert decrease_score (miss), clear combo, and return to IDLE; otherwise SHALL decrement counter.
REQ-020 Hits SHALL be accepted at edges k+1..k+WINDOW after arrival at edge k; a miss SHALL be signalled at edge k+WINDOW.
REQ-021 A note_arrive in PENDING SHALL first judge the old note at that edge (hit, wrong, or, if no press, miss regardless of counter), then load the new note and stay in PENDING.
REQ-022 Score outputs SHALL be registered, high for exactly the one cycle following the judging edge (1-cycle latency).
REQ-023 increase_score and decrease_score SHALL never be high in the same cycle; at most one judgement SHALL occur per edge.
REQ-024 pending SHALL be high exactly when the state is PENDING.

Reset
REQ-025 resetn low SHALL immediately, without a clock, force state IDLE, counter 0, stored type 0, drum registers 0, increase_score 0, decrease_score 0, combo 0, and pending 0.
REQ-026 Reset asserted mid-window SHALL discard the pending note without any score pulse, including after release.
REQ-027 After resetn rises, a drum held high SHALL NOT count as a press until it is released and pressed again.

Verification
REQ-028 WINDOW=16: note_arrive type 0 at edge 10, drum_don rises at edge 15 -> increase_score high for 1 cycle after edge 15, combo 0->1, pending low.
REQ-029 Note type 1 at edge 10, no press -> decrease_score high for 1 cycle after edge 26, combo cleared; a press at edge 26 SHALL instead give increase_score.
REQ-030 Note type 0 pending, drum_don and drum_ka rise at the same edge -> decrease_score pulse, combo 0.
REQ-031 Note A pending, no press, note B arrives at edge 20 -> decrease_score after edge 20, pending stays high, B judged on its own window.
REQ-032 Fire 300 consecutive correct hits -> combo saturates at 255; a following miss -> combo 0.
REQ-033 Note pending, resetn pulsed low for 3 ns mid-cycle -> all outputs 0 asynchronously, and no score pulse ever follows for that note.
